// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared constants and types for the cache miss refill logic.
//   WORDS_PER_BLOCK   : 16-bit words in one cache block
//   BLOCK_OFFSET_MASK : clears the byte offset to give the block base address
//   fill_state_t      : refill controller states
// ---------------------------------------------------------------------------
package cache_pkg;

    localparam int          WORDS_PER_BLOCK   = 8;
    localparam logic [15:0] BLOCK_OFFSET_MASK = 16'hFFF0;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/cache_fill_counter.sv
// ---------------------------------------------------------------------------
// cache_fill_counter
// 4-bit word counter used for both the request (issue) and response (receive)
// side of a block refill.
//   clk   : system clock
//   clr_n : synchronous active-low clear (also carries the block reset)
//   inc   : count up by one this cycle
//   count : current count
//   done  : count has reached LIMIT
// ---------------------------------------------------------------------------
module cache_fill_counter
    import cache_pkg::*;
#(
    parameter int LIMIT = WORDS_PER_BLOCK
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       inc,
    output logic [3:0] count,
    output logic       done
);

    // Enabled flop: clear wins over increment so a new fill always starts at 0.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= 4'd0;
        end else if (inc) begin
            count <= count + 4'd1;
        end
    end

    assign done = (count == 4'(LIMIT));

endmodule

// File: rtl/cache_fill_fsm.sv
// ---------------------------------------------------------------------------
// cache_fill_fsm
// Cache miss refill controller. On a miss it streams one block of WORDS
// words from the pipelined memory (one request per cycle, no backpressure),
// writes each returned word into the data array, writes the tag array on the
// last word and holds the pipeline stalled for the whole refill.
//   clk, rst_n          : clock, synchronous active-low reset
//   miss_detected       : miss reported for miss_address this cycle
//   miss_address        : byte address of the missing access
//   memory_data_valid   : memory_data carries a returned word
//   memory_data         : returned word
//   fsm_busy            : refill in progress (pipeline stall)
//   mem_en              : read request this cycle at memory_address
//   memory_address      : byte address of the read request
//   write_data_array    : write cache_data at cache_word_offset
//   cache_word_offset   : word index in the block
//   cache_data          : word to write (memory_data passthrough)
//   write_tag_array     : one-cycle pulse writing tag and valid bit
// ---------------------------------------------------------------------------
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int WORDS  = WORDS_PER_BLOCK,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    input  logic [DATA_W-1:0] memory_data,
    output logic              fsm_busy,
    output logic              mem_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [2:0]        cache_word_offset,
    output logic [DATA_W-1:0] cache_data,
    output logic              write_tag_array
);

    fill_state_t       state;
    logic [ADDR_W-1:0] base;
    logic [3:0]        issue_cnt;
    logic [3:0]        recv_cnt;
    logic              issue_done;
    logic              recv_done;
    logic              in_fill;
    logic              start_fill;
    logic              word_accept;
    logic              last_word;
    logic              cnt_clr_n;

    assign in_fill    = (state == FILL);
    assign start_fill = (state == IDLE) && miss_detected;

    // Returned words only count while filling; stray valids in IDLE and
    // responses still in flight after a reset are dropped here.
    assign word_accept = in_fill && memory_data_valid && !recv_done;
    assign last_word   = word_accept && (recv_cnt == 4'(WORDS - 1));

    // Both counters restart from zero when a new miss is accepted.
    assign cnt_clr_n = rst_n && !start_fill;

    // State register: leave IDLE on a miss, return once the last word lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (start_fill || last_word) begin
            state <= start_fill ? FILL : IDLE;
        end
    end

    // Block base is captured once per fill so misses reported mid-fill
    // cannot move the request stream to another block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base <= '0;
        end else if (start_fill) begin
            base <= miss_address & ADDR_W'(BLOCK_OFFSET_MASK);
        end
    end

    cache_fill_counter #(
        .LIMIT (WORDS)
    ) u_issue_cnt (
        .clk   (clk),
        .clr_n (cnt_clr_n),
        .inc   (in_fill && !issue_done),
        .count (issue_cnt),
        .done  (issue_done)
    );

    cache_fill_counter #(
        .LIMIT (WORDS)
    ) u_recv_cnt (
        .clk   (clk),
        .clr_n (cnt_clr_n),
        .inc   (word_accept),
        .count (recv_cnt),
        .done  (recv_done)
    );

    assign fsm_busy = in_fill;
    assign mem_en   = in_fill && !issue_done;

    // Word index to byte offset; the base is block aligned so the add never
    // carries out of the block and the top bit simply wraps.
    assign memory_address = mem_en ? (base + ADDR_W'({issue_cnt, 1'b0})) : '0;

    assign write_data_array  = word_accept;
    assign cache_word_offset = word_accept ? recv_cnt[2:0] : 3'd0;
    assign cache_data        = word_accept ? memory_data : '0;
    assign write_tag_array   = last_word;

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Cache miss refill controller for the WISC CPU memory subsystem. On a cache miss it reads one 16-byte block (eight 16-bit words) from the pipelined, fixed-latency main memory and writes each returned word into the cache data array. It writes the tag array once the block is complete, then releases the pipeline stall. It sits between the I-/D-cache arbitration logic and the multi-cycle memory module, one instance per cache.

## Interface

Parameters:

- WORDS: 8. Words per cache block.
- ADDR_W: 16. Byte-address width.
- DATA_W: 16. Word width.

Ports:

- clk  input  1  system clock, all state updated on rising edge
- rst_n  input  1  reset, synchronous, active-low
- miss_detected  input  1  cache reports a miss for miss_address this cycle
- miss_address  input  ADDR_W  byte address of the missing access
- memory_data_valid  input  1  memory_data holds a returned word this cycle
- memory_data  input  DATA_W  word returned by memory
- fsm_busy  output  1  refill in progress; the pipeline stalls while high
- mem_en  output  1  read request to memory this cycle
- memory_address  output  ADDR_W  byte address of the read request
- write_data_array  output  1  write cache_data at cache_word_offset this cycle
- cache_word_offset  output  3  word index within the block for the data-array write
- cache_data  output  DATA_W  word to write; equals memory_data
- write_tag_array  output  1  single-cycle pulse that writes the tag and valid bit for the block

Decided: one clock, clk; reset rst_n is synchronous and active-low.

## Operation

- The FSM has two states, IDLE and FILL.
- **Reset (rst_n=0 at an edge):**
  - state goes to IDLE.
  - Issue and receive counters go to 0.
  - The latched base address goes to 0.
  - All outputs read 0: fsm_busy, mem_en, memory_address, write_data_array, cache_word_offset, cache_data, write_tag_array.
- **IDLE → FILL:** taken when miss_detected=1.
  - base is latched as miss_address & 16'hFFF0.
  - Both counters are cleared.
- **In FILL:**
  - mem_en=1 while issue_cnt<8.
  - memory_address = base + (issue_cnt<<1).
  - issue_cnt increments every cycle until it reaches 8, with no backpressure. Memory accepts one request per cycle.
  - When memory_data_valid=1:
    - write_data_array=1.
    - cache_word_offset = recv_cnt[2:0].
    - cache_data = memory_data.
    - recv_cnt increments.
- **FILL → IDLE:** taken on the cycle the 8th word arrives (recv_cnt=7 with memory_data_valid=1).
  - write_data_array=1 and write_tag_array=1 in that same cycle.
  - The FSM is in IDLE on the next cycle.
- fsm_busy=1 exactly while state=FILL, including the final write cycle. It is a registered state decode.
- miss_detected while in FILL, including the final cycle, is ignored. The latched base never changes mid-fill.
- memory_data_valid while in IDLE is ignored: no writes, no counter change.
- write_data_array and cache_data are combinational from memory_data_valid and memory_data, gated by state=FILL.
- memory_address wraps modulo 2^16. The block base is always 16-byte aligned, so no carry crosses a block boundary.
- Reset asserted mid-fill:
  - The fill aborts and no tag write occurs.
  - Words still in flight in memory that return after reset are ignored.

## Timing

- miss_detected sampled high at edge T (state IDLE):
  - FILL from T+1.
  - mem_en high for cycles T+1..T+8.
  - Addresses are base, base+2, …, base+14.
- With 4-cycle memory latency:
  - data returns T+5..T+12.
  - write_tag_array pulses at T+12.
  - fsm_busy is high T+1..T+12 and low at T+13.
- Total stall is 12 cycles per miss.
- Completion is driven only by memory_data_valid count, never by a fixed latency, so gaps in valid lengthen the fill.
- A new miss can be accepted at the earliest in the first IDLE cycle, T+13.
- Back-to-back misses, with miss_detected held high across completion, start a second fill at T+14.

## Structure

- **Shared package cache_pkg:**
  - WORDS_PER_BLOCK=8.
  - BLOCK_OFFSET_MASK=16'hFFF0.
  - State enum fill_state_t {IDLE, FILL}.
- **Sub-module cache_fill_counter:**
  - 4-bit counter with synchronous active-low clear, increment enable and a done flag (count==8).
  - Built from the team's enabled flip-flops.
  - Instantiated twice, once for issue and once for receive.
- The state register and base register use the same enabled-flop style.

## Test plan

- **Basic fill:** miss_address=16'h1234, 4-cycle memory.
  - mem_en addresses 16'h1230..16'h123E over 8 consecutive cycles.
  - Offsets 0..7 written with the returned data.
  - write_tag_array at cycle T+12; fsm_busy low at T+13.
- **Irregular valid:** insert 2 idle cycles between words 3 and 4.
  - write_tag_array is delayed by exactly 2 cycles.
  - Offsets stay contiguous 0..7.
- **Miss while busy:** pulse miss_detected with address 16'hABCD during FILL.
  - Ignored; all addresses stay in block 16'h1230.
- **Stray valid:** assert memory_data_valid in IDLE.
  - write_data_array=0, no counter change, and the next fill still starts at offset 0.
- **Reset mid-fill:** drop rst_n at cycle T+6.
  - All outputs are 0 the next cycle.
  - No write_tag_array pulse.
  - Late valids ignored.
- **Wrap and back-to-back:** miss_address=16'hFFFF.
  - Addresses 16'hFFF0..16'hFFFE.
  - miss_detected held high through completion starts a second fill at T+14.
